// File: rtl/motor_speed_sequencer_pkg.sv
// Shared types and constants for the motor speed sequencer: FSM state
// encoding, speed level codes, direction codes and the one-level step helper.
package motor_speed_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP    = 3'd1,
        RAMP_DN = 3'd2,
        DWELL   = 3'd3,
        ESTOP   = 3'd4
    } seq_state_e;

    localparam logic [1:0] SPD_STOP = 2'b00;
    localparam logic [1:0] SPD_LOW  = 2'b01;
    localparam logic [1:0] SPD_MID  = 2'b10;
    localparam logic [1:0] SPD_HIGH = 2'b11;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Move one level from cur toward tgt. Saturating by construction: it only
    // adds when below the target and only subtracts when above it, so the
    // 2-bit level can never wrap between 11 and 00.
    function automatic logic [1:0] step_toward(input logic [1:0] cur,
                                               input logic [1:0] tgt);
        logic [1:0] nxt;
        if (cur < tgt) begin
            nxt = cur + 2'd1;
        end else if (cur > tgt) begin
            nxt = cur - 2'd1;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/motor_speed_sequencer_if.sv
// Command handshake between the drive decision logic (master) and the
// speed sequencer (slave): target speed/direction qualified by valid/ready.
interface motor_speed_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_speed;
    logic       cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_speed,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_speed,
        input  cmd_dir,
        output cmd_ready
    );

endinterface

// File: rtl/motor_speed_sequencer_tick_timer.sv
// Terminal-count tick counter shared by the ramp and dwell phases.
// Counts 0..last_i while enabled, raises done_o on the terminal count and
// wraps back to zero on that same edge; clear_i forces the count to zero.
module motor_speed_sequencer_tick_timer #(
    parameter int CNT_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    // Terminal count is reached on the cycle where the count equals last_i.
    always_comb begin
        done_o = en_i && (cnt_q == last_i);
    end

    // Count register: clear has priority, then wrap on done, else increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (en_i) begin
            if (done_o) begin
                cnt_q <= {CNT_W{1'b0}};
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/motor_speed_sequencer.sv
// Speed-select sequencer for the PWM generator. Accepts target speed and
// direction commands, ramps the 2-bit speed level one step per STEP_TICKS,
// and reverses only after ramping to zero and dwelling DWELL_TICKS there.
// estop forces the level to zero immediately and overrides everything.
module motor_speed_sequencer
    import motor_speed_sequencer_pkg::*;
#(
    parameter int STEP_TICKS  = 5_000_000,
    parameter int DWELL_TICKS = 2_500_000,
    parameter int CNT_W       = 23
) (
    input  logic                        clk,
    input  logic                        rst_n,
    motor_speed_sequencer_if.slave      cmd,
    input  logic                        estop_i,
    output logic [1:0]                  speed_sel_o,
    output logic                        motor_dir_o,
    output logic                        busy_o
);

    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_TICKS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);

    seq_state_e       state_q;
    logic [1:0]       spd_q;
    logic             dir_q;
    logic [1:0]       tgt_spd_q;
    logic             tgt_dir_q;
    logic             ready_q;
    logic             busy_q;

    logic [1:0]       spd_d;
    logic             tmr_en_s;
    logic             tmr_clr_s;
    logic [CNT_W-1:0] tmr_last_s;
    logic             tmr_done_s;
    logic             xfer_s;

    // A transfer needs the registered ready seen by the master; estop still
    // wins on that same edge, so a colliding command is simply dropped.
    always_comb begin
        xfer_s = cmd.cmd_valid && ready_q && !estop_i;
    end

    // Timer control: count in the moving/dwelling states, hold at zero
    // elsewhere so every phase starts from a fresh count.
    always_comb begin
        tmr_en_s   = 1'b0;
        tmr_clr_s  = 1'b0;
        tmr_last_s = STEP_LAST;
        if (estop_i) begin
            tmr_clr_s = 1'b1;
        end else begin
            case (state_q)
                RAMP, RAMP_DN: begin
                    tmr_en_s = 1'b1;
                end
                DWELL: begin
                    tmr_en_s   = 1'b1;
                    tmr_last_s = DWELL_LAST;
                end
                default: begin
                    tmr_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Candidate next level for the current phase (applied only on done).
    always_comb begin
        spd_d = spd_q;
        case (state_q)
            RAMP:    spd_d = step_toward(spd_q, tgt_spd_q);
            RAMP_DN: spd_d = step_toward(spd_q, SPD_STOP);
            default: spd_d = spd_q;
        endcase
    end

    motor_speed_sequencer_tick_timer #(
        .CNT_W (CNT_W)
    ) u_tick_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (tmr_clr_s),
        .en_i    (tmr_en_s),
        .last_i  (tmr_last_s),
        .done_o  (tmr_done_s)
    );

    // Sequencer FSM with its target latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            spd_q     <= SPD_STOP;
            dir_q     <= DIR_FWD;
            tgt_spd_q <= SPD_STOP;
            tgt_dir_q <= DIR_FWD;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else if (estop_i) begin
            // Level drops to zero at once; direction and target are kept.
            state_q <= ESTOP;
            spd_q   <= SPD_STOP;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer_s) begin
                        tgt_spd_q <= cmd.cmd_speed;
                        tgt_dir_q <= cmd.cmd_dir;
                        if (cmd.cmd_dir != dir_q) begin
                            state_q <= (spd_q != SPD_STOP) ? RAMP_DN : DWELL;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (cmd.cmd_speed != spd_q) begin
                            state_q <= RAMP;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            // Already at the requested level: accept as a no-op.
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                RAMP: begin
                    if (tmr_done_s) begin
                        spd_q <= spd_d;
                        if (spd_d == tgt_spd_q) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RAMP;
                        end
                    end else begin
                        state_q <= RAMP;
                    end
                end
                RAMP_DN: begin
                    if (tmr_done_s) begin
                        spd_q <= spd_d;
                        if (spd_d == SPD_STOP) begin
                            state_q <= DWELL;
                        end else begin
                            state_q <= RAMP_DN;
                        end
                    end else begin
                        state_q <= RAMP_DN;
                    end
                end
                DWELL: begin
                    if (tmr_done_s) begin
                        // The only place direction may change, at level zero.
                        dir_q <= tgt_dir_q;
                        if (tgt_spd_q == SPD_STOP) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RAMP;
                        end
                    end else begin
                        state_q <= DWELL;
                    end
                end
                ESTOP: begin
                    // Release returns to a stopped idle; the old target is dropped.
                    state_q   <= IDLE;
                    tgt_spd_q <= SPD_STOP;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    spd_q   <= SPD_STOP;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign speed_sel_o   = spd_q;
    assign motor_dir_o   = dir_q;
    assign busy_o        = busy_q;

endmodule
